mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction-fetch requester and the data requester of the pipelined CPU.
- Sits between the datapath's imemreq/dmemreq/dmemwreq paths and the RAM model.
- Data requests have fixed priority, with a starvation guard so fetch always makes progress.
- Provides per-requester wait handshakes, a RAM timeout and error reporting.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one RAM port between fetch and data requesters
// Data has fixed priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_arbiter #(
  parameter int WORD_W       = 32,
  parameter int MAX_WAIT     = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WORD_W-1:0] BAD_WORD = WORD_W'(32'hBAD1BAD1);

  state_t          state;
  logic [WC_W-1:0] waitcnt;
  logic [SC_W-1:0] starvecnt;

  logic d_req;
  logic active;
  logic access;
  logic fault;
  logic done;
  logic starve_full;

  assign d_req       = dREN | dWEN;
  assign active      = (state == DGRANT && d_req) || (state == IGRANT && iREN);
  assign access      = (ramstate == RAM_ACCESS);
  // An ACCESS in the timeout cycle still counts as a good completion.
  assign fault       = active && !access &&
                       (ramstate == RAM_ERROR || waitcnt == WC_W'(MAX_WAIT));
  assign done        = access | fault;
  assign starve_full = (starvecnt == SC_W'(STARVE_LIMIT));

  assign dwait = d_req & ~(state == DGRANT && done);
  assign iwait = iREN  & ~(state == IGRANT && done);

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    case (state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = fault ? BAD_WORD : ramload;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = fault ? BAD_WORD : ramload;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      waitcnt   <= '0;
      starvecnt <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          waitcnt <= '0;
          if (d_req && !(iREN && starve_full)) begin
            state <= DGRANT;
            if (!iREN)
              starvecnt <= '0;
            else if (!starve_full)
              starvecnt <= starvecnt + SC_W'(1);
          end else if (iREN) begin
            state     <= IGRANT;
            starvecnt <= '0;
          end
        end
        DGRANT, IGRANT: begin
          // A withdrawn request releases the port quietly, even at the timeout point.
          if (!active) begin
            state   <= IDLE;
            waitcnt <= '0;
          end else if (done) begin
            state   <= IDLE;
            waitcnt <= '0;
            err     <= fault;
          end else begin
            waitcnt <= waitcnt + WC_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          waitcnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven and sequence checks for mem_arbiter
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = FREE;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        iren;
    logic [31:0] ia;
    logic        dren;
    logic        dwen;
    logic [31:0] da;
    logic [31:0] ds;
    logic [31:0] rl;
    logic [1:0]  rs;
    logic        x_iwait;
    logic        x_dwait;
    logic        x_ren;
    logic        x_wen;
    logic [31:0] x_raddr;
    logic [31:0] x_rstore;
    logic [31:0] x_iload;
    logic [31:0] x_dload;
    logic        x_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] ds,
                       input logic [31:0] rl, input logic [1:0] rs);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ramload = rl; ramstate = rs;
  endtask

  initial begin
    //             iren ia    dren dwen da    ds            rl            rs  | iw dw ren wen raddr  rstore        iload         dload         err
    vecs.push_back('{1, 32'h40, 0, 0, 32'h0,   32'h0,        32'h2402000A, ACC,  1, 0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{1, 32'h40, 0, 0, 32'h0,   32'h0,        32'h2402000A, ACC,  0, 0, 1, 0, 32'h40,  32'h0,        32'h2402000A, 32'h0,        0});
    vecs.push_back('{0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{1, 32'h44, 0, 1, 32'h100, 32'hDEADBEEF, 32'h11111111, BUSY, 1, 1, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{1, 32'h44, 0, 1, 32'h100, 32'hDEADBEEF, 32'h11111111, BUSY, 1, 1, 0, 1, 32'h100, 32'hDEADBEEF, 32'h0,        32'h11111111, 0});
    vecs.push_back('{1, 32'h44, 0, 1, 32'h100, 32'hDEADBEEF, 32'h22222222, ACC,  1, 0, 0, 1, 32'h100, 32'hDEADBEEF, 32'h0,        32'h22222222, 0});
    vecs.push_back('{1, 32'h44, 0, 0, 32'h0,   32'h0,        32'h8C220004, ACC,  1, 0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{1, 32'h44, 0, 0, 32'h0,   32'h0,        32'h8C220004, ACC,  0, 0, 1, 0, 32'h44,  32'h0,        32'h8C220004, 32'h0,        0});
    vecs.push_back('{0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{1, 32'h48, 0, 0, 32'h0,   32'h0,        32'h12345678, ERR,  1, 0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{1, 32'h48, 0, 0, 32'h0,   32'h0,        32'h12345678, ERR,  0, 0, 1, 0, 32'h48,  32'h0,        32'hBAD1BAD1, 32'h0,        0});
    vecs.push_back('{0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        1});
    vecs.push_back('{0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{0, 32'h0,  1, 0, 32'h300, 32'h0,        32'h33333333, BUSY, 0, 1, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{0, 32'h0,  1, 0, 32'h300, 32'h0,        32'h33333333, BUSY, 0, 1, 1, 0, 32'h300, 32'h0,        32'h0,        32'h33333333, 0});
    vecs.push_back('{0, 32'h0,  0, 0, 32'h300, 32'h0,        32'h33333333, BUSY, 0, 0, 0, 0, 32'h300, 32'h0,        32'h0,        32'h33333333, 0});
    vecs.push_back('{0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{0, 32'h0,  1, 1, 32'h304, 32'hCAFEF00D, 32'h44444444, ACC,  0, 1, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{0, 32'h0,  1, 1, 32'h304, 32'hCAFEF00D, 32'h44444444, ACC,  0, 0, 0, 1, 32'h304, 32'hCAFEF00D, 32'h0,        32'h44444444, 0});
    vecs.push_back('{0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        FREE, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        0});

    // Reset state with requests present: waits follow requests, RAM side quiet.
    drive(1, 32'h10, 1, 0, 32'h20, 32'h0, 32'h99999999, ACC);
    #2;
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_iload", iload, 32'h0);
    chk("rst_dload", dload, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, FREE);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i].iren, vecs[i].ia, vecs[i].dren, vecs[i].dwen,
            vecs[i].da, vecs[i].ds, vecs[i].rl, vecs[i].rs);
      #2;
      chk($sformatf("v%0d_iwait", i), 32'(iwait), 32'(vecs[i].x_iwait));
      chk($sformatf("v%0d_dwait", i), 32'(dwait), 32'(vecs[i].x_dwait));
      chk($sformatf("v%0d_ramREN", i), 32'(ramREN), 32'(vecs[i].x_ren));
      chk($sformatf("v%0d_ramWEN", i), 32'(ramWEN), 32'(vecs[i].x_wen));
      chk($sformatf("v%0d_ramaddr", i), ramaddr, vecs[i].x_raddr);
      chk($sformatf("v%0d_ramstore", i), ramstore, vecs[i].x_rstore);
      chk($sformatf("v%0d_iload", i), iload, vecs[i].x_iload);
      chk($sformatf("v%0d_dload", i), dload, vecs[i].x_dload);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].x_err));
    end

    // Starvation: four data grants, then fetch is forced on the fifth decision.
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      drive(1, 32'h80, 1, 0, 32'h500, 32'h0, 32'h0, ACC);
      #2;
      chk($sformatf("stv%0d_ramREN", k), 32'(ramREN), 32'(k % 2));
      chk($sformatf("stv%0d_ramaddr", k), ramaddr,
          (k % 2 == 0) ? 32'h0 : (k == 9) ? 32'h80 : 32'h500);
      chk($sformatf("stv%0d_iwait", k), 32'(iwait), (k == 9) ? 32'd0 : 32'd1);
      chk($sformatf("stv%0d_dwait", k), 32'(dwait), (k % 2 == 1 && k != 9) ? 32'd0 : 32'd1);
      if (k == 8) chk("stv_sat", 32'(dut.starvecnt), 32'd4);
      if (k == 10) chk("stv_clear", 32'(dut.starvecnt), 32'd0);
    end
    @(negedge CLK);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, FREE);

    // Timeout after MAX_WAIT busy cycles in DGRANT.
    for (int k = 0; k < 19; k++) begin
      @(negedge CLK);
      drive(0, 32'h0, (k < 17), 0, 32'h600, 32'h0, 32'h55555555, BUSY);
      #2;
      chk($sformatf("to%0d_ramREN", k), 32'(ramREN), (k >= 1 && k <= 16) ? 32'd1 : 32'd0);
      chk($sformatf("to%0d_dwait", k), 32'(dwait), (k <= 15) ? 32'd1 : 32'd0);
      chk($sformatf("to%0d_dload", k), dload,
          (k == 16) ? 32'hBAD1BAD1 : (k >= 1 && k <= 15) ? 32'h55555555 : 32'h0);
      chk($sformatf("to%0d_err", k), 32'(err), (k == 17) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset in the middle of a data grant.
    @(negedge CLK);
    drive(1, 32'h84, 1, 0, 32'h700, 32'h0, 32'h0, BUSY);
    @(negedge CLK);
    #2;
    chk("mr_grant_ramREN", 32'(ramREN), 32'd1);
    chk("mr_grant_ramaddr", ramaddr, 32'h700);
    #1 nRST = 1'b0;
    #1;
    chk("mr_ramREN", 32'(ramREN), 32'd0);
    chk("mr_ramaddr", ramaddr, 32'h0);
    chk("mr_dwait", 32'(dwait), 32'd1);
    chk("mr_iwait", 32'(iwait), 32'd1);
    chk("mr_starve", 32'(dut.starvecnt), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #2;
    chk("mr_rel_ramREN", 32'(ramREN), 32'd0);
    chk("mr_rel_err", 32'(err), 32'd0);
    chk("mr_rel_dwait", 32'(dwait), 32'd1);
    @(negedge CLK);
    #2;
    chk("mr_regrant_ramREN", 32'(ramREN), 32'd1);
    chk("mr_regrant_ramaddr", ramaddr, 32'h700);
    chk("mr_regrant_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
